ddr_lane_dly_seq: RTL and testbench
===================================

DDR_LANE_DLY_SEQ -- requirements
Module: ddr_lane_dly_seq

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of lane delay lines controlled (1..8).
REQ-002 SHALL have parameter TAP_W, default 8, width of tap position and step count.
REQ-003 SHALL have parameter MAX_TAP, default 255, highest legal tap position.
REQ-004 SHALL have parameter PAUSE_PRE, default 2, and PAUSE_POST, default 2, cycles of clock pause before and after moves (each 1..15).
REQ-005 SHALL have port FAB_CLK, input, 1, the single clock; all logic rising-edge FAB_CLK.
REQ-006 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports REQ_VALID in 1, REQ_READY out 1, request handshake.
REQ-008 SHALL have ports REQ_LANE in LW, REQ_OP in 2, REQ_COUNT in TAP_W; LW = max(1,$clog2(NUM_LANES)); ops 00 INC, 01 DEC, 10 LOAD, 11 reserved.
REQ-009 SHALL have ports DONE out 1 and DONE_ERR out 1, one-cycle completion pulse and error flag.
REQ-010 SHALL have ports DELAY_LINE_SEL out NUM_LANES (one-hot), DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE out 1 each, to lane controllers.
REQ-011 SHALL have port HS_IO_CLK_PAUSE, out, 1, high-speed clock pause to all lanes.
REQ-012 SHALL have port OUT_OF_RANGE, in, NUM_LANES, per-lane delay line out-of-range status.
REQ-013 SHALL have port TAP_POS, out, NUM_LANES*TAP_W, tracked tap position per lane, lane i at [i*TAP_W +: TAP_W].

Function
REQ-014 SHALL implement FSM IDLE -> PRE -> SETUP -> MOVE <-> GAP -> POST -> DONE -> IDLE.
REQ-015 REQ_READY SHALL be high only in IDLE; request accepted on edge with REQ_VALID && REQ_READY; fields latched then.
REQ-016 PRE SHALL last PAUSE_PRE cycles, SETUP 1 cycle, each tap MOVE 1 cycle + GAP 1 cycle, POST PAUSE_POST cycles, DONE 1 cycle.
REQ-017 HS_IO_CLK_PAUSE SHALL be high from first PRE cycle through last POST cycle, low in IDLE and DONE.
REQ-018 DELAY_LINE_SEL (one-hot of latched lane) and DELAY_LINE_DIRECTION (1 INC, 0 DEC) SHALL be stable from SETUP through last GAP, zero otherwise.
REQ-019 DELAY_LINE_MOVE SHALL be high exactly in MOVE cycles; selected TAP_POS SHALL +1 (INC) or -1 (DEC) on that edge.
REQ-020 Before each MOVE, INC at MAX_TAP or DEC at 0 SHALL skip the move, go to POST and set DONE_ERR.
REQ-021 OUT_OF_RANGE of selected lane sampled high in any GAP SHALL end moves, go to POST, set DONE_ERR.
REQ-022 REQ_COUNT=0 for INC/DEC SHALL issue no MOVE but still run PRE/SETUP/POST/DONE, DONE_ERR=0.
REQ-023 LOAD SHALL assert DELAY_LINE_LOAD for the single SETUP cycle and clear selected TAP_POS to 0; REQ_COUNT ignored.
REQ-024 REQ_LANE >= NUM_LANES or op 11 SHALL go directly to DONE with DONE_ERR=1, no pause, no strobes.
REQ-025 DONE_ERR SHALL be valid only with DONE, 0 otherwise.

Reset
REQ-026 RESET SHALL on the next edge force IDLE, REQ_READY=1, all other outputs 0, all TAP_POS 0, including mid-operation; no DONE for the aborted request.

Configuration
REQ-027 With macro DDR_DLY_CLK_PAUSE_EN defined, PRE/POST states and HS_IO_CLK_PAUSE SHALL behave per REQ-016/017.
REQ-028 Without DDR_DLY_CLK_PAUSE_EN, PRE and POST SHALL be skipped (IDLE->SETUP, last GAP->DONE) and HS_IO_CLK_PAUSE tied 0.

Structure
REQ-029 Package ddr_dly_pkg SHALL hold the op encoding and FSM state typedefs.
REQ-030 Per-lane tap tracking SHALL be sub-module ddr_dly_tap_cnt (inc/dec/clear, saturation flags), instantiated NUM_LANES times.

Verification
REQ-031 Defaults, macro on: INC lane 2 count 3 -> 3 MOVE pulses, SEL=0100, DIR=1, DONE 12 cycles after accept, TAP_POS lane2=3.
REQ-032 Macro off: same request -> DONE 8 cycles after accept, HS_IO_CLK_PAUSE never high.
REQ-033 DEC lane 0 at tap 1 count 4 -> 1 MOVE, tap 0, DONE with DONE_ERR=1.
REQ-034 INC lane 1 count 10, OUT_OF_RANGE[1] high in 3rd GAP -> 3 MOVEs, DONE_ERR=1, pause released after PAUSE_POST.
REQ-035 LOAD lane 3 at tap 50 -> one DELAY_LINE_LOAD pulse, TAP_POS lane3=0; REQ_LANE=5 -> DONE+DONE_ERR next cycle.
REQ-036 RESET during 2nd MOVE -> next cycle all outputs 0, REQ_READY=1, no DONE.

Source files
------------

// File: rtl/ddr_dly_pkg.sv
// Shared types for the DDR lane delay-line sequencer: request op encoding,
// FSM states and the lane-select width helper.
package ddr_dly_pkg;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_RSVD = 2'b11
    } dly_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SETUP = 3'd2,
        ST_MOVE  = 3'd3,
        ST_GAP   = 3'd4,
        ST_POST  = 3'd5,
        ST_DONE  = 3'd6
    } dly_state_e;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_dly_tap_cnt.sv
// Tap position tracker for one lane delay line: saturating inc/dec,
// synchronous clear, and at-limit flags used to refuse illegal moves.
module ddr_dly_tap_cnt #(
    parameter int TAP_W   = 8,
    parameter int MAX_TAP = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [TAP_W-1:0] tap,
    output logic             at_max,
    output logic             at_zero
);

    logic [TAP_W-1:0] tap_q;

    assign at_max  = (tap_q == TAP_W'(MAX_TAP));
    assign at_zero = (tap_q == '0);
    assign tap     = tap_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tap_q <= '0;
        end else if (inc && !at_max) begin
            tap_q <= tap_q + TAP_W'(1);
        end else if (dec && !at_zero) begin
            tap_q <= tap_q - TAP_W'(1);
        end
    end

endmodule

// File: rtl/ddr_lane_dly_seq.sv
// Sequencer stepping one lane delay line per request, wrapping moves in a
// high-speed clock pause when DDR_DLY_CLK_PAUSE_EN is defined.
//
// Request handshake: REQ_READY is high only in IDLE; a request is taken on the
// rising edge where REQ_VALID && REQ_READY, and its lane/op/count are latched
// on that edge. Completion is a one-cycle DONE pulse with DONE_ERR alongside.
module ddr_lane_dly_seq
    import ddr_dly_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int TAP_W      = 8,
    parameter int MAX_TAP    = 255,
    parameter int PAUSE_PRE  = 2,
    parameter int PAUSE_POST = 2
) (
    input  logic                         FAB_CLK,
    input  logic                         RESET,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic [lane_w(NUM_LANES)-1:0] REQ_LANE,
    input  logic [1:0]                   REQ_OP,
    input  logic [TAP_W-1:0]             REQ_COUNT,
    output logic                         DONE,
    output logic                         DONE_ERR,
    output logic [NUM_LANES-1:0]         DELAY_LINE_SEL,
    output logic                         DELAY_LINE_LOAD,
    output logic                         DELAY_LINE_DIRECTION,
    output logic                         DELAY_LINE_MOVE,
    output logic                         HS_IO_CLK_PAUSE,
    input  logic [NUM_LANES-1:0]         OUT_OF_RANGE,
    output logic [NUM_LANES*TAP_W-1:0]   TAP_POS,
    output logic [2:0]                   dbg_state
);

    localparam int LW = lane_w(NUM_LANES);

`ifdef DDR_DLY_CLK_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    dly_state_e       state_q, state_nxt;
    dly_op_e          op_q, op_nxt;
    logic [LW-1:0]    lane_q, lane_nxt;
    logic [TAP_W-1:0] rem_q, rem_nxt;
    logic [3:0]       cnt_q, cnt_nxt;
    logic             err_q, err_nxt;

    logic                 ready_q, done_q, done_err_q, load_q, dir_q, move_q, pause_q;
    logic [NUM_LANES-1:0] sel_q, sel_nxt;

    logic [NUM_LANES-1:0] lane_max, lane_zero;
    logic                 sel_max, sel_zero, sel_oor, lane_ok, in_win;
    logic                 end_moves, try_move;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic hit;
            assign hit = (lane_q == LW'(gi));
            ddr_dly_tap_cnt #(.TAP_W(TAP_W), .MAX_TAP(MAX_TAP)) u_tap (
                .clk     (FAB_CLK),
                .rst     (RESET),
                .inc     (hit && state_q == ST_MOVE && op_q == OP_INC),
                .dec     (hit && state_q == ST_MOVE && op_q == OP_DEC),
                .clr     (hit && state_q == ST_SETUP && op_q == OP_LOAD),
                .tap     (TAP_POS[gi*TAP_W +: TAP_W]),
                .at_max  (lane_max[gi]),
                .at_zero (lane_zero[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_max  = 1'b0;
        sel_zero = 1'b0;
        sel_oor  = 1'b0;
        sel_nxt  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LW'(i)) begin
                sel_max  = lane_max[i];
                sel_zero = lane_zero[i];
                sel_oor  = OUT_OF_RANGE[i];
            end
            sel_nxt[i] = (lane_nxt == LW'(i));
        end
    end

    assign lane_ok = (int'(REQ_LANE) < NUM_LANES);

    always_comb begin
        state_nxt = state_q;
        op_nxt    = op_q;
        lane_nxt  = lane_q;
        rem_nxt   = rem_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        end_moves = 1'b0;
        try_move  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    op_nxt   = dly_op_e'(REQ_OP);
                    lane_nxt = REQ_LANE;
                    rem_nxt  = REQ_COUNT;
                    err_nxt  = 1'b0;
                    if (!lane_ok || dly_op_e'(REQ_OP) == OP_RSVD) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end else if (PAUSE_EN) begin
                        state_nxt = ST_PRE;
                        cnt_nxt   = 4'(PAUSE_PRE - 1);
                    end else begin
                        state_nxt = ST_SETUP;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) state_nxt = ST_SETUP;
                else             cnt_nxt   = cnt_q - 4'd1;
            end
            ST_SETUP: begin
                if (op_q == OP_LOAD) end_moves = 1'b1;
                else                 try_move  = 1'b1;
            end
            ST_MOVE: begin
                rem_nxt   = rem_q - TAP_W'(1);
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (sel_oor) begin
                    err_nxt   = 1'b1;
                    end_moves = 1'b1;
                end else begin
                    try_move = 1'b1;
                end
            end
            ST_POST: begin
                if (cnt_q == '0) state_nxt = ST_DONE;
                else             cnt_nxt   = cnt_q - 4'd1;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // A move that would run past either end of the line is refused, not clipped.
        if (try_move) begin
            if (rem_q == '0) begin
                end_moves = 1'b1;
            end else if ((op_q == OP_INC && sel_max) || (op_q == OP_DEC && sel_zero)) begin
                err_nxt   = 1'b1;
                end_moves = 1'b1;
            end else begin
                state_nxt = ST_MOVE;
            end
        end
        if (end_moves) begin
            if (PAUSE_EN) begin
                state_nxt = ST_POST;
                cnt_nxt   = 4'(PAUSE_POST - 1);
            end else begin
                state_nxt = ST_DONE;
            end
        end
    end

    assign in_win = (state_nxt == ST_SETUP) || (state_nxt == ST_MOVE) || (state_nxt == ST_GAP);

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_INC;
            lane_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            load_q     <= 1'b0;
            dir_q      <= 1'b0;
            move_q     <= 1'b0;
            pause_q    <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            op_q       <= op_nxt;
            lane_q     <= lane_nxt;
            rem_q      <= rem_nxt;
            cnt_q      <= cnt_nxt;
            err_q      <= err_nxt;
            ready_q    <= (state_nxt == ST_IDLE);
            done_q     <= (state_nxt == ST_DONE);
            done_err_q <= (state_nxt == ST_DONE) && err_nxt;
            load_q     <= (state_nxt == ST_SETUP) && (op_nxt == OP_LOAD);
            dir_q      <= in_win && (op_nxt == OP_INC);
            move_q     <= (state_nxt == ST_MOVE);
            pause_q    <= PAUSE_EN && (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            sel_q      <= in_win ? sel_nxt : '0;
        end
    end

    assign REQ_READY            = ready_q;
    assign DONE                 = done_q;
    assign DONE_ERR             = done_err_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_ddr_lane_dly_seq.sv
// Directed self-checking bench for ddr_lane_dly_seq at default parameters;
// expected latencies follow DDR_DLY_CLK_PAUSE_EN when it is defined.
module tb_ddr_lane_dly_seq;

`ifdef DDR_DLY_CLK_PAUSE_EN
    localparam int PAUSE_SUM = 4;
    localparam int PAUSE_ON  = 1;
`else
    localparam int PAUSE_SUM = 0;
    localparam int PAUSE_ON  = 0;
`endif

    logic        FAB_CLK = 1'b0;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [1:0]  REQ_LANE;
    logic [1:0]  REQ_OP;
    logic [7:0]  REQ_COUNT;
    logic        DONE, DONE_ERR;
    logic [3:0]  DELAY_LINE_SEL;
    logic        DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
    logic        HS_IO_CLK_PAUSE;
    logic [3:0]  OUT_OF_RANGE;
    logic [31:0] TAP_POS;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    int r_lat, r_moves, r_loads, r_err, r_pause, r_pause_at_done, r_sel, r_dir, r_bad_err;

    ddr_lane_dly_seq dut (
        .FAB_CLK              (FAB_CLK),
        .RESET                (RESET),
        .REQ_VALID            (REQ_VALID),
        .REQ_READY            (REQ_READY),
        .REQ_LANE             (REQ_LANE),
        .REQ_OP               (REQ_OP),
        .REQ_COUNT            (REQ_COUNT),
        .DONE                 (DONE),
        .DONE_ERR             (DONE_ERR),
        .DELAY_LINE_SEL       (DELAY_LINE_SEL),
        .DELAY_LINE_LOAD      (DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION (DELAY_LINE_DIRECTION),
        .DELAY_LINE_MOVE      (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE      (HS_IO_CLK_PAUSE),
        .OUT_OF_RANGE         (OUT_OF_RANGE),
        .TAP_POS              (TAP_POS),
        .dbg_state            (dbg_state)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tap(input int i);
        return int'(TAP_POS[i*8 +: 8]);
    endfunction

    // Latency from accept edge to DONE cycle for a request issuing m moves.
    function automatic int lat_mov(input int m);
        return PAUSE_SUM + 2 + 2 * m;
    endfunction

    function automatic int pause_mov(input int m);
        return PAUSE_ON * (PAUSE_SUM + 1 + 2 * m);
    endfunction

    task automatic send(input int lane, input int op, input int cnt);
        int n;
        n = 0;
        @(negedge FAB_CLK);
        while (!REQ_READY && n < 100) begin
            @(negedge FAB_CLK);
            n++;
        end
        if (!REQ_READY) check("ready_timeout", 0, 1);
        REQ_VALID = 1'b1;
        REQ_LANE  = 2'(lane);
        REQ_OP    = 2'(op);
        REQ_COUNT = 8'(cnt);
        @(posedge FAB_CLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    // Issue one request and observe every cycle until DONE; oor_gap>0 raises
    // OUT_OF_RANGE of the lane during that GAP (the cycle after a MOVE).
    task automatic run_req(input int lane, input int op, input int cnt, input int oor_gap);
        int gaps;
        bit prev_move, got;
        send(lane, op, cnt);
        r_lat = 0; r_moves = 0; r_loads = 0; r_err = 0; r_pause = 0;
        r_pause_at_done = 0; r_sel = 0; r_dir = 0; r_bad_err = 0;
        gaps = 0; prev_move = 1'b0; got = 1'b0;
        for (int k = 1; k <= 1200 && !got; k++) begin
            @(negedge FAB_CLK);
            OUT_OF_RANGE = '0;
            if (prev_move) begin
                gaps++;
                if (gaps == oor_gap) OUT_OF_RANGE[lane] = 1'b1;
            end
            prev_move = DELAY_LINE_MOVE;
            if (DELAY_LINE_MOVE) begin
                r_moves++;
                r_sel |= int'(DELAY_LINE_SEL);
                r_dir |= int'(DELAY_LINE_DIRECTION);
            end
            if (DELAY_LINE_LOAD) r_loads++;
            if (HS_IO_CLK_PAUSE) r_pause++;
            if (DONE_ERR && !DONE) r_bad_err++;
            if (DONE) begin
                r_lat = k;
                r_err = int'(DONE_ERR);
                r_pause_at_done = int'(HS_IO_CLK_PAUSE);
                got = 1'b1;
            end
        end
        OUT_OF_RANGE = '0;
        if (!got) check("done_timeout", 0, 1);
    endtask

    initial begin
        int n, seen_done;
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_LANE = '0; REQ_OP = '0; REQ_COUNT = '0;
        OUT_OF_RANGE = '0;
        repeat (3) @(posedge FAB_CLK);
        #1;
        check("rst_ready", REQ_READY, 1);
        check("rst_done", {DONE, DONE_ERR}, 0);
        check("rst_strobes", {DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, HS_IO_CLK_PAUSE}, 0);
        check("rst_tap", TAP_POS, 0);
        @(negedge FAB_CLK);
        RESET = 1'b0;

        // INC lane 2 by 3
        run_req(2, 0, 3, 0);
        check("inc_moves", r_moves, 3);
        check("inc_sel", r_sel, 4'b0100);
        check("inc_dir", r_dir, 1);
        check("inc_lat", r_lat, lat_mov(3));
        check("inc_err", r_err, 0);
        check("inc_pause", r_pause, pause_mov(3));
        check("inc_tap2", tap(2), 3);
        check("inc_tap_others", tap(0) + tap(1) + tap(3), 0);

        // DEC lane 0 from tap 1 by 4: one move then blocked at 0
        run_req(0, 0, 1, 0);
        check("pre_dec_tap0", tap(0), 1);
        run_req(0, 1, 4, 0);
        check("dec_moves", r_moves, 1);
        check("dec_sel", r_sel, 4'b0001);
        check("dec_dir", r_dir, 0);
        check("dec_tap0", tap(0), 0);
        check("dec_err", r_err, 1);
        check("dec_lat", r_lat, lat_mov(1));

        // INC lane 1 by 10 with out-of-range reported in the 3rd GAP
        run_req(1, 0, 10, 3);
        check("oor_moves", r_moves, 3);
        check("oor_err", r_err, 1);
        check("oor_tap1", tap(1), 3);
        check("oor_lat", r_lat, lat_mov(3));
        check("oor_pause", r_pause, pause_mov(3));
        check("oor_pause_at_done", r_pause_at_done, 0);

        // Zero-count INC: no move, no error
        run_req(1, 0, 0, 0);
        check("zero_moves", r_moves, 0);
        check("zero_err", r_err, 0);
        check("zero_lat", r_lat, lat_mov(0));
        check("zero_tap1", tap(1), 3);

        // LOAD lane 3 from tap 50
        run_req(3, 0, 50, 0);
        check("pre_load_tap3", tap(3), 50);
        run_req(3, 2, 77, 0);
        check("load_pulses", r_loads, 1);
        check("load_moves", r_moves, 0);
        check("load_tap3", tap(3), 0);
        check("load_err", r_err, 0);
        check("load_lat", r_lat, lat_mov(0));

        // Reserved op: straight to DONE with error, no pause
        run_req(1, 3, 5, 0);
        check("rsvd_lat", r_lat, 1);
        check("rsvd_err", r_err, 1);
        check("rsvd_pause", r_pause, 0);
        check("rsvd_tap1", tap(1), 3);

        // Saturate lane 0 at MAX_TAP, then a further INC is refused
        run_req(0, 0, 255, 0);
        check("max_tap0", tap(0), 255);
        run_req(0, 0, 2, 0);
        check("max_moves", r_moves, 0);
        check("max_err", r_err, 1);
        check("max_lat", r_lat, lat_mov(0));
        check("max_tap0_hold", tap(0), 255);

        check("err_outside_done", r_bad_err, 0);

        // Reset during the 2nd MOVE
        send(2, 0, 3);
        n = 0;
        for (int k = 0; k < 40 && n < 2; k++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) n++;
        end
        check("rst_mid_reached_move2", n, 2);
        RESET = 1'b1;
        @(posedge FAB_CLK);
        #1;
        check("rst_mid_ready", REQ_READY, 1);
        check("rst_mid_outs", {DONE, DONE_ERR, DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, HS_IO_CLK_PAUSE}, 0);
        check("rst_mid_tap", TAP_POS, 0);
        @(negedge FAB_CLK);
        RESET = 1'b0;
        seen_done = 0;
        repeat (15) begin
            @(negedge FAB_CLK);
            if (DONE) seen_done++;
        end
        check("rst_mid_no_done", seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
